// File: rtl/combination_lock_pkg.sv
// Shared types and constants for the 0-1-0-1-1 combination lock.
// Optional auto-relock is enabled by defining COMBINATION_LOCK_RELOCK_EN.
package combination_lock_pkg;

    localparam int CODE_LEN = 5;

    // First digit of the code is in the MSB.
    localparam logic [CODE_LEN-1:0] CODE = 5'b01011;

    localparam int TIMER_W = 16;

    typedef enum logic [2:0] {
        S0   = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        S4   = 3'd4,
        OPEN = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        D0   = 2'd0,
        D1   = 2'd1,
        IDLE = 2'd2,
        BAD  = 2'd3
    } event_t;

    function automatic event_t classify(input logic zero, input logic one);
        event_t ev;
        case ({zero, one})
            2'b10:   ev = D0;
            2'b01:   ev = D1;
            2'b00:   ev = IDLE;
            default: ev = BAD;
        endcase
        return ev;
    endfunction

    // Digit the code expects after 'matched' digits have already been accepted.
    function automatic logic code_digit(input logic [2:0] matched);
        logic [CODE_LEN-1:0] code_v;
        logic digit;
        code_v = CODE;
        digit  = 1'b0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (matched == 3'(i)) digit = code_v[CODE_LEN-1-i];
        end
        return digit;
    endfunction

endpackage

// File: rtl/combination_lock_relock_timer.sv
// Idle counter that signals when OPEN has been idle for RELOCK_CYCLES cycles.
// Built only when COMBINATION_LOCK_RELOCK_EN is defined.
module combination_lock_relock_timer
    import combination_lock_pkg::*;
#(
    parameter int RELOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic running,
    input  logic idle,
    output logic expire
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(RELOCK_CYCLES - 1);

    logic [TIMER_W-1:0] count;

    // Expire on the idle edge that would make the count reach RELOCK_CYCLES.
    assign expire = running && idle && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (!running) begin
            count <= '0;
        end else if (idle && !expire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/combination_lock.sv
// Moore FSM detecting the serial code 0-1-0-1-1 with overlap-aware fallback.
// Define COMBINATION_LOCK_RELOCK_EN to relock OPEN after RELOCK_CYCLES idle cycles.
module combination_lock
    import combination_lock_pkg::*;
#(
    parameter int RELOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic zero,
    input  logic one,
    output logic unlock
);

    state_t state;
    state_t state_next;
    event_t ev;
    logic   relock;

    if (RELOCK_CYCLES < 1 || RELOCK_CYCLES > 65535) begin : g_bad_relock
        $error("RELOCK_CYCLES must be in 1..65535");
    end

    assign ev = classify(zero, one);

`ifdef COMBINATION_LOCK_RELOCK_EN
    combination_lock_relock_timer #(
        .RELOCK_CYCLES(RELOCK_CYCLES)
    ) u_relock_timer (
        .clk    (clk),
        .rst    (rst),
        .running(state == OPEN),
        .idle   (ev == IDLE),
        .expire (relock)
    );
`else
    assign relock = 1'b0;
`endif

    // On a wrong digit, fall back to the longest code prefix that is a
    // suffix of what has been entered.
    function automatic state_t fallback(input state_t s);
        state_t f;
        case (s)
            S1:      f = S1;
            S3:      f = S1;
            S4:      f = S3;
            default: f = S0;
        endcase
        return f;
    endfunction

    function automatic state_t advance(input state_t s);
        state_t a;
        case (s)
            S0:      a = S1;
            S1:      a = S2;
            S2:      a = S3;
            S3:      a = S4;
            S4:      a = OPEN;
            default: a = S0;
        endcase
        return a;
    endfunction

    function automatic logic is_valid(input state_t s);
        return s inside {S0, S1, S2, S3, S4, OPEN};
    endfunction

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned and infers a latch.
        state_next = S0;
        if (!is_valid(state) || relock) begin
            state_next = S0;
        end else begin
            case (ev)
                IDLE: state_next = state;
                BAD:  state_next = S0;
                default: begin
                    if (state == OPEN) begin
                        state_next = (ev == D0) ? S1 : S0;
                    end else if ((ev == D1) == code_digit(state)) begin
                        state_next = advance(state);
                    end else begin
                        state_next = fallback(state);
                    end
                end
            endcase
        end
    end

    // unlock is registered alongside the state so it is a clean Moore output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S0;
            unlock <= 1'b0;
        end else begin
            state  <= state_next;
            unlock <= (state_next == OPEN);
        end
    end

endmodule

// File: tb/tb_combination_lock.sv
// Self-checking bench for combination_lock: a vector table plus directed
// sequences for relock and asynchronous reset.
module tb_combination_lock;
    import combination_lock_pkg::*;

    logic clk;
    logic rst;
    logic zero;
    logic one;
    logic unlock;

    int checks = 0;
    int errors = 0;

    combination_lock #(
        .RELOCK_CYCLES(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .zero  (zero),
        .one   (one),
        .unlock(unlock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic   z;
        logic   o;
        logic   exp_unlock;
        state_t exp_state;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic exp_u, input state_t exp_s);
        check({name, " unlock"}, {7'd0, unlock}, {7'd0, exp_u});
        check({name, " state"}, {5'd0, dut.state}, {5'd0, exp_s});
    endtask

    // Drive one cycle of inputs; return 1 time unit after the sampling edge.
    task automatic step(input logic z, input logic o);
        zero = z;
        one  = o;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic z, input logic o, input logic u, input state_t s);
        vec_t v;
        v.z = z; v.o = o; v.exp_unlock = u; v.exp_state = s;
        vecs.push_back(v);
    endtask

    task automatic enter_code();
        step(0, 1); step(1, 0); step(0, 1); step(1, 0); step(0, 1); step(0, 1);
        check_out("code entry", 1'b1, OPEN);
    endtask

    initial begin
        // Wrong entry 0,1,1,1,1 then the correct code.
        add(1,0, 0,S1); add(0,1, 0,S2); add(0,1, 0,S0); add(0,1, 0,S0); add(0,1, 0,S0);
        add(1,0, 0,S1); add(0,1, 0,S2); add(1,0, 0,S3); add(0,1, 0,S4); add(0,1, 1,OPEN);
        add(0,1, 0,S0);
        // Overlap 0,1,0,1,0,1,1 exercising S4 --D0--> S3.
        add(1,0, 0,S1); add(0,1, 0,S2); add(1,0, 0,S3); add(0,1, 0,S4); add(1,0, 0,S3);
        add(0,1, 0,S4); add(0,1, 1,OPEN);
        add(1,0, 0,S1);
        // 0, IDLE x3, 1, 0, 1, 1 (starting from S1).
        add(1,0, 0,S1); add(0,0, 0,S1); add(0,0, 0,S1); add(0,0, 0,S1);
        add(0,1, 0,S2); add(1,0, 0,S3); add(0,1, 0,S4); add(0,1, 1,OPEN);
        add(1,1, 0,S0);
        // 0,1,0,BAD,1,1.
        add(1,0, 0,S1); add(0,1, 0,S2); add(1,0, 0,S3); add(1,1, 0,S0);
        add(0,1, 0,S0); add(0,1, 0,S0); add(1,1, 0,S0);

        rst  = 1'b0;
        zero = 1'b0;
        one  = 1'b0;
        #1;
        check_out("in reset", 1'b0, S0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(0, 0);
        step(0, 0);
        check_out("after reset", 1'b0, S0);

        foreach (vecs[i]) begin
            step(vecs[i].z, vecs[i].o);
            check_out($sformatf("vec %0d", i), vecs[i].exp_unlock, vecs[i].exp_state);
        end

        // Relock behaviour under long idle.
        enter_code();
`ifdef COMBINATION_LOCK_RELOCK_EN
        for (int i = 1; i <= 3; i++) begin
            step(0, 0);
            check_out($sformatf("relock idle %0d", i), 1'b1, OPEN);
        end
        step(0, 0);
        check_out("relock timeout", 1'b0, S0);
        enter_code();
`else
        for (int i = 1; i <= 100; i++) begin
            step(0, 0);
            check_out($sformatf("hold idle %0d", i), 1'b1, OPEN);
        end
`endif
        step(0, 1);
        check_out("d1 in open", 1'b0, S0);

        // Asynchronous reset between edges after 0,1,0,1.
        step(1, 0); step(0, 1); step(1, 0); step(0, 1);
        check_out("before async reset", 1'b0, S4);
        #3;
        rst = 1'b0;
        #1;
        check_out("async reset", 1'b0, S0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(0, 1);
        check_out("single 1 after reset", 1'b0, S0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/combination_lock.md
# combination_lock

Synchronous combination-lock controller that watches a serial stream of single-bit digits on two strobe inputs (`zero`, `one`) and asserts `unlock` once the fixed code `0-1-0-1-1` has been entered. It is a Moore state machine with overlap-aware sequence detection, so a partially correct prefix inside a wrong entry is not lost. The block sits behind the keypad debounce/strobe logic and drives the latch-release logic of the enclosing design.

## Interface
- `RELOCK_CYCLES`, default 16: number of idle clock cycles spent in OPEN before automatic relock. Used only when `COMBINATION_LOCK_RELOCK_EN` is defined; range 1..65535.
- `clk` input 1: single system clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `zero` input 1: digit strobe for "0", sampled on each rising edge.
- `one` input 1: digit strobe for "1", sampled on each rising edge.
- `unlock` output 1: high while the FSM is in OPEN; decoded only from state (Moore).

## Operation
- States: S0 (nothing matched), S1 ("0"), S2 ("01"), S3 ("010"), S4 ("0101"), OPEN ("01011").
- Each rising edge classifies the inputs into one event:
  - D0: `zero`=1, `one`=0.
  - D1: `zero`=0, `one`=1.
  - IDLE: both low.
  - BAD: both high.
- IDLE: state holds in every state.
- BAD: next state is S0 from every state.
- Transitions for D0 / D1:
  - S0: D0 -> S1, D1 -> S0.
  - S1: D0 -> S1, D1 -> S2.
  - S2: D0 -> S3, D1 -> S0.
  - S3: D0 -> S1, D1 -> S4.
  - S4: D0 -> S3, D1 -> OPEN.
  - OPEN: D0 -> S1, D1 -> S0.
- These transitions give overlap-aware detection: on a mismatch, the FSM falls back to the longest code prefix that is a suffix of the digits entered so far.
- `unlock` = 1 only in OPEN. A new digit entered while open relocks immediately.
- The state register uses a 3-bit encoding. Unused encodings go to S0 on the next edge.

## Timing
- Reset: while `rst` is low, state = S0 and `unlock` = 0, both immediately (asynchronous).
- Release of `rst` takes effect at the first rising edge after deassertion.
- Latency: `unlock` rises at the same rising edge that samples the fifth correct digit. It is visible before the next digit can be sampled.
- `unlock` falls at the edge that samples any D0, D1 or BAD while in OPEN.
- With the relock feature, `unlock` also falls at the relock timeout.
- Inputs are assumed synchronous to `clk`; the block does not synchronise them.
- One digit is consumed per cycle when a strobe is held. A strobe held for k cycles counts as k digits.

## Configuration
- Macro: `COMBINATION_LOCK_RELOCK_EN`.
- With the macro defined:
  - A 16-bit idle counter clears on entry to OPEN.
  - It increments on each IDLE cycle spent in OPEN.
  - When it reaches `RELOCK_CYCLES`, the next state is S0 and `unlock` falls at that edge.
  - The counter resets to 0 asynchronously with `rst`.
- Without the macro: no counter exists, and OPEN holds indefinitely under IDLE.

## Structure
- Package `combination_lock_pkg`:
  - State enum (S0..S4, OPEN) with the explicit 3-bit encoding.
  - Event enum (D0, D1, IDLE, BAD).
  - Constant `CODE_LEN` = 5.
  - Constant `CODE` = 5'b01011 (first digit in the MSB).
- Optional sub-module `combination_lock_relock_timer`: the idle counter and terminal-count compare. It is instantiated only under `COMBINATION_LOCK_RELOCK_EN`.
- The FSM lives in `combination_lock` itself.

## Test plan
- Reset: hold `rst` low for 1 cycle, release, then 2 IDLE cycles -> `unlock` = 0 and state S0.
- Wrong entry: digits 0,1,1,1,1 -> `unlock` stays 0 throughout and the state ends in S0. Then enter 0,1,0,1,1 -> `unlock` = 1 after the fifth edge.
- Overlap: digits 0,1,0,1,0,1,1 -> `unlock` = 1 only after the seventh edge. The S4 --D0--> S3 fallback is exercised.
- IDLE gaps and BAD:
  - 0, IDLE×3, 1, 0, 1, 1 -> `unlock` = 1.
  - 0,1,0,BAD,1,1 -> `unlock` = 0 and the state is S0.
- Relock:
  - Without the macro: OPEN, then 100 IDLE cycles -> `unlock` stays 1.
  - With the macro and `RELOCK_CYCLES` = 4: `unlock` falls at the 4th IDLE edge.
  - In both builds: a D1 in OPEN -> `unlock` = 0.
- Async reset mid-sequence: after 0,1,0,1, drive `rst` low between edges -> `unlock` = 0 and state S0 immediately. After release, a single 1 does not unlock.
